// File: rtl/pc_unit_stack.sv
// rtl/pc_unit_stack.sv - program counter with relative/absolute jumps and a return-address stack
module pc_unit_stack #(
    parameter int              PC_W        = 16,
    parameter logic [PC_W-1:0] RST_VEC     = '0,
    parameter logic [PC_W-1:0] INC         = PC_W'(1),
    parameter int              STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            PC_rst,
    input  logic            stall,
    input  logic [2:0]      op,
    input  logic [PC_W-1:0] PC_next,
    output logic [PC_W-1:0] PC,
    output logic            stack_empty,
    output logic            stack_full,
    output logic            stack_err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_REL  = 3'd2;
    localparam logic [2:0] OP_ABS  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, full_q, err_q;
    logic             err_d, push;
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic [PC_W-1:0]  stack_mem [STACK_DEPTH];

    // The count doubles as the write pointer; the top entry sits one below it.
    // When full the pointer wraps to zero, which is never written because pushes are refused.
    assign wr_idx = cnt_q[PTR_W-1:0];
    assign rd_idx = wr_idx - PTR_W'(1);

    // Decode the op into next PC, next count, push strobe and error flag; stall keeps everything.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        push  = 1'b0;
        if (!stall) begin
            case (op)
                OP_HOLD: pc_d = pc_q;
                OP_REL:  pc_d = pc_q + PC_next;
                OP_ABS:  pc_d = PC_next;
                OP_CALL: begin
                    if (full_q) begin
                        err_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        pc_d  = PC_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (empty_q) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d  = stack_mem[rd_idx];
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: pc_d = pc_q + INC;
            endcase
        end
    end

    // PC, count and status flags; reset discards everything regardless of the clock.
    always_ff @(posedge clk or posedge PC_rst) begin
        if (PC_rst) begin
            pc_q    <= RST_VEC;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CNT_W'(STACK_DEPTH));
            err_q   <= err_d;
        end
    end

    // Return-address storage; entries are left in place on pop and need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[wr_idx] <= pc_q + INC;
        end
    end

    assign PC          = pc_q;
    assign stack_empty = empty_q;
    assign stack_full  = full_q;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_unit_stack.sv
// tb/tb_pc_unit_stack.sv - directed bench for pc_unit_stack
module tb_pc_unit_stack;

    logic        clk;
    logic        PC_rst;
    logic        stall;
    logic [2:0]  op;
    logic [15:0] PC_next;
    logic [15:0] PC;
    logic        stack_empty;
    logic        stack_full;
    logic        stack_err;

    int total = 0;
    int bad   = 0;

    pc_unit_stack #(
        .PC_W(16), .RST_VEC(16'h0000), .INC(16'h0001), .STACK_DEPTH(4)
    ) dut (
        .clk(clk), .PC_rst(PC_rst), .stall(stall), .op(op), .PC_next(PC_next),
        .PC(PC), .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [15:0] n, input logic s);
        op      = o;
        PC_next = n;
        stall   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_pc, input logic e_empty,
                             input logic e_full, input logic e_err);
        check({tag, ".pc"},    32'(PC),          32'(e_pc));
        check({tag, ".empty"}, 32'(stack_empty), 32'(e_empty));
        check({tag, ".full"},  32'(stack_full),  32'(e_full));
        check({tag, ".err"},   32'(stack_err),   32'(e_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PC_rst  = 1'b0;
        stall   = 1'b0;
        op      = 3'd0;
        PC_next = 16'h0000;

        // reset before any clock edge
        #1 PC_rst = 1'b1;
        #1 check_all("rst", 16'h0000, 1'b1, 1'b0, 1'b0);
        #1 PC_rst = 1'b0;

        // increment and wrap
        do_op(3'd1, 16'h0000, 1'b0); check("inc1", 32'(PC), 32'h0001);
        do_op(3'd1, 16'h0000, 1'b0); check("inc2", 32'(PC), 32'h0002);
        do_op(3'd7, 16'h0000, 1'b0); check("inc7", 32'(PC), 32'h0003);
        do_op(3'd3, 16'hFFFF, 1'b0); check("absffff", 32'(PC), 32'hFFFF);
        do_op(3'd1, 16'h0000, 1'b0); check("wrap", 32'(PC), 32'h0000);
        do_op(3'd0, 16'h1234, 1'b0); check("hold", 32'(PC), 32'h0000);

        // relative branch backwards, then stall
        do_op(3'd3, 16'h0010, 1'b0); check("abs10", 32'(PC), 32'h0010);
        do_op(3'd2, 16'hFFFE, 1'b0); check("rel_neg", 32'(PC), 32'h000E);
        do_op(3'd1, 16'h0000, 1'b1); check_all("stall1", 16'h000E, 1'b1, 1'b0, 1'b0);
        do_op(3'd1, 16'h0000, 1'b1); check("stall2", 32'(PC), 32'h000E);
        do_op(3'd2, 16'h0004, 1'b0); check("rel_pos", 32'(PC), 32'h0012);

        // single call / return
        do_op(3'd3, 16'h0005, 1'b0);
        do_op(3'd4, 16'h0100, 1'b0); check_all("call1", 16'h0100, 1'b0, 1'b0, 1'b0);
        do_op(3'd5, 16'h0000, 1'b0); check_all("ret1",  16'h0006, 1'b1, 1'b0, 1'b0);

        // fill the stack, overflow, unwind, underflow
        do_op(3'd3, 16'h0020, 1'b0);
        do_op(3'd4, 16'h0100, 1'b0); check_all("fill1", 16'h0100, 1'b0, 1'b0, 1'b0);
        do_op(3'd4, 16'h0200, 1'b0); check("fill2", 32'(PC), 32'h0200);
        do_op(3'd4, 16'h0300, 1'b0); check_all("fill3", 16'h0300, 1'b0, 1'b0, 1'b0);
        do_op(3'd4, 16'h0400, 1'b0); check_all("fill4", 16'h0400, 1'b0, 1'b1, 1'b0);
        do_op(3'd4, 16'h0500, 1'b0); check_all("ovf1", 16'h0400, 1'b0, 1'b1, 1'b1);
        do_op(3'd4, 16'h0600, 1'b0); check_all("ovf2", 16'h0400, 1'b0, 1'b1, 1'b1);
        do_op(3'd4, 16'h0700, 1'b1); check_all("ovf_stall", 16'h0400, 1'b0, 1'b1, 1'b0);
        do_op(3'd0, 16'h0000, 1'b0); check_all("ovf_clr", 16'h0400, 1'b0, 1'b1, 1'b0);
        do_op(3'd5, 16'h0000, 1'b0); check_all("unw1", 16'h0301, 1'b0, 1'b0, 1'b0);
        do_op(3'd5, 16'h0000, 1'b0); check("unw2", 32'(PC), 32'h0201);
        do_op(3'd5, 16'h0000, 1'b0); check("unw3", 32'(PC), 32'h0101);
        do_op(3'd5, 16'h0000, 1'b0); check_all("unw4", 16'h0021, 1'b1, 1'b0, 1'b0);
        do_op(3'd5, 16'h0000, 1'b0); check_all("udf", 16'h0021, 1'b1, 1'b0, 1'b1);
        do_op(3'd0, 16'h0000, 1'b0); check_all("udf_clr", 16'h0021, 1'b1, 1'b0, 1'b0);

        // reset mid-operation with two entries pushed
        do_op(3'd4, 16'h0100, 1'b0);
        do_op(3'd4, 16'h0200, 1'b0); check_all("pre_rst", 16'h0200, 1'b0, 1'b0, 1'b0);
        op = 3'd3; PC_next = 16'h1234;
        #2 PC_rst = 1'b1;
        #1 check_all("async_rst", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_all("rst_held", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        PC_rst = 1'b0;
        do_op(3'd5, 16'h0000, 1'b0); check_all("ret_after_rst", 16'h0000, 1'b1, 1'b0, 1'b1);
        do_op(3'd1, 16'h0000, 1'b0); check_all("inc_after_rst", 16'h0001, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
